// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if: soft-reset handshake and per-domain reset outputs.
// master drives soft_req; slave (the sequencer) drives everything else.
interface reset_sequencer_if #(
  parameter int NUM_DOMAINS = 3
);
  logic                   soft_req;
  logic                   soft_ack;
  logic [NUM_DOMAINS-1:0] rst_out;
  logic                   seq_done;

  modport master (
    output soft_req,
    input  soft_ack,
    input  rst_out,
    input  seq_done
  );

  modport slave (
    input  soft_req,
    output soft_ack,
    output rst_out,
    output seq_done
  );
endinterface

// File: rtl/reset_sequencer.sv
// reset_sequencer: synchronises reset release, then frees domains in
// ascending order after a hold delay; a soft request replays the order.
module reset_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_DOMAINS = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int STEP_CYCLES = 8
) (
  input  logic               clk,
  input  logic               reset,
  reset_sequencer_if.slave   bus
);

  localparam int MAXC = (HOLD_CYCLES > STEP_CYCLES) ?
                        HOLD_CYCLES : STEP_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int IW   = (NUM_DOMAINS > 1) ?
                        $clog2(NUM_DOMAINS) : 1;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STEP_LAST = CW'(STEP_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST  =
    IW'((NUM_DOMAINS > 1) ? NUM_DOMAINS - 1 : 0);

  typedef enum logic [1:0] {
    ST_ASSERT,
    ST_HOLD,
    ST_RELEASE,
    ST_RUN
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rst_sync_n;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d, idx_n;
  logic [NUM_DOMAINS-1:0] rst_q, rst_d;
  logic                   done_q, done_d;
  logic                   ack_q, ack_d;
  logic                   armed_q, armed_d;

  // Deassertion synchroniser: shifts in ones once reset is released.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_sync_n = sync_q[SYNC_STAGES-1];

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_ASSERT;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '1;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
      armed_q <= armed_d;
    end
  end

  // Next state: hold, stepped release, then wait for an armed soft request.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    done_d  = done_q;
    ack_d   = 1'b0;
    armed_d = armed_q;
    idx_n   = idx_q + IW'(1);

    unique case (state_q)
      ST_ASSERT: begin
        rst_d  = '1;
        done_d = 1'b0;
        if (rst_sync_n) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      end

      ST_HOLD: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == HOLD_LAST) begin
          cnt_d    = '0;
          idx_d    = '0;
          rst_d[0] = 1'b0;
          if (NUM_DOMAINS == 1) begin
            state_d = ST_RUN;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RELEASE;
          end
        end
      end

      ST_RELEASE: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == STEP_LAST) begin
          cnt_d        = '0;
          idx_d        = idx_n;
          rst_d[idx_n] = 1'b0;
          if (idx_n == IDX_LAST) begin
            state_d = ST_RUN;
            done_d  = 1'b1;
          end
        end
      end

      ST_RUN: begin
        // Requester must drop soft_req once in RUN before it can retrigger.
        if (bus.soft_req && armed_q) begin
          rst_d   = '1;
          done_d  = 1'b0;
          ack_d   = 1'b1;
          armed_d = 1'b0;
          cnt_d   = '0;
          state_d = ST_HOLD;
        end else if (!bus.soft_req) begin
          armed_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_ASSERT;
      end
    endcase
  end

  assign bus.rst_out  = rst_q;
  assign bus.seq_done = done_q;
  assign bus.soft_ack = ack_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed edge-by-edge checks of the default
// sequencer plus a 1-domain, 1-cycle-hold instance sharing clk/reset.
module tb_reset_sequencer;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  int n_checks = 0;
  int n_errors = 0;
  int s_hold;

  always #5 clk = ~clk;

  reset_sequencer_if #(.NUM_DOMAINS(3)) u_if0 ();
  reset_sequencer_if #(.NUM_DOMAINS(1)) u_if1 ();

  reset_sequencer u_dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if0.slave)
  );

  reset_sequencer #(
    .SYNC_STAGES (2),
    .NUM_DOMAINS (1),
    .HOLD_CYCLES (1),
    .STEP_CYCLES (8)
  ) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if1.slave)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask

  // Soft request level sampled at edge e (hand-written schedule).
  function automatic logic sreq(input int e);
    return (e <= 50) || (e == 100) ||
           (e >= 150 && e <= 199) || (e == 220);
  endfunction

  // Edges at which a soft request must be accepted.
  function automatic logic ack_at(input int e);
    return (e == 100) || (e == 150) || (e == 220);
  endfunction

  // Default config: domain k released at s + 16 + 8k.
  function automatic logic [2:0] exp_rst(input int e, input int s);
    if (e < s + 16) return 3'b111;
    if (e < s + 24) return 3'b110;
    if (e < s + 32) return 3'b100;
    return 3'b000;
  endfunction

  task automatic run_edge(input int e);
    logic [2:0] er;
    logic       ea;
    u_if0.soft_req = sreq(e);
    @(posedge clk);
    #1;
    ea = ack_at(e);
    if (ea) s_hold = e;
    er = exp_rst(e, s_hold);
    check("rst_out", 32'(u_if0.rst_out), 32'(er));
    check("seq_done", 32'(u_if0.seq_done), 32'(er == 3'b000));
    check("soft_ack", 32'(u_if0.soft_ack), 32'(ea));
    check("d1_rst", 32'(u_if1.rst_out), 32'(e < 4));
    check("d1_done", 32'(u_if1.seq_done), 32'(e >= 4));
  endtask

  initial begin
    u_if0.soft_req = 1'b1;
    u_if1.soft_req = 1'b0;
    #1 reset = 1'b0;
    #1;
    check("rst_rst_out", 32'(u_if0.rst_out), 32'h7);
    check("rst_done", 32'(u_if0.seq_done), 32'h0);
    check("rst_ack", 32'(u_if0.soft_ack), 32'h0);
    check("rst_d1", 32'(u_if1.rst_out), 32'h1);
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold_out", 32'(u_if0.rst_out), 32'h7);
    check("rst_hold_done", 32'(u_if0.seq_done), 32'h0);

    @(negedge clk);
    reset = 1'b1;
    s_hold = 3;
    for (int e = 1; e <= 22; e++) run_edge(e);

    #3 reset = 1'b0;
    #1;
    check("async_rst_out", 32'(u_if0.rst_out), 32'h7);
    check("async_done", 32'(u_if0.seq_done), 32'h0);
    check("async_d1_rst", 32'(u_if1.rst_out), 32'h1);
    check("async_d1_done", 32'(u_if1.seq_done), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    s_hold = 3;
    for (int e = 1; e <= 255; e++) run_edge(e);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Sits between the raw board/testbench clock and reset source and the tb_top/SoC fabric.
- Synchronises deassertion of an asynchronous active-low reset.
- Releases a set of active-high synchronous per-domain resets in a fixed order, with programmable hold and step delays.
- Accepts a software-initiated soft reset request, which re-runs the release sequence without the input reset.

Parameters:
- SYNC_STAGES, 2: synchroniser flop count, minimum 2.
- NUM_DOMAINS, 3: number of reset domains, 1..8. Domain 0 (interconnect/memory) is released first.
- HOLD_CYCLES, 16: cycles all domains stay in reset after sync release or soft request, minimum 1.
- STEP_CYCLES, 8: cycles between successive domain releases, minimum 1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- soft_req  in  1  level soft-reset request
- soft_ack  out  1  one-cycle pulse on soft request acceptance
- rst_out  out  NUM_DOMAINS  active-high synchronous resets, one bit per domain
- seq_done  out  1  high when all domains are released

Behaviour:
- One clock. reset is asynchronous and active-low.

Reset (reset low):
- Takes effect immediately, without waiting for a clock edge.
- Synchroniser flops = 0, FSM = ASSERT, rst_out = all ones, seq_done = 0, soft_ack = 0.
- Hold and step counters = 0, domain index = 0, soft_armed = 0.

Synchroniser:
- Chain of SYNC_STAGES flops shifting in 1.
- Output rst_sync_n goes high after SYNC_STAGES rising edges of reset-high sampling.
- Edge 1 is the first rising edge at which reset is high.

FSM states and transitions:
- ASSERT: rst_out all ones. When rst_sync_n == 1 -> HOLD, counter cleared.
- HOLD: rst_out all ones. Counter increments each cycle. When counter == HOLD_CYCLES-1 -> RELEASE, and rst_out[0] clears on the same edge; counter cleared, index = 0.
- RELEASE: counter increments each cycle. When counter == STEP_CYCLES-1, index increments and rst_out[index] clears on the same edge.
  - When the last domain clears -> RUN, with seq_done = 1 on that same edge.
  - With NUM_DOMAINS == 1, HOLD goes directly to RUN while clearing rst_out[0].
- RUN: all rst_out = 0, seq_done = 1. soft_armed sets on any cycle with soft_req == 0.
  - If soft_req == 1 and soft_armed == 1 at an edge:
    - rst_out = all ones, seq_done = 0, soft_ack = 1 for exactly one cycle;
    - soft_armed = 0, counter cleared, state -> HOLD.
  - The synchroniser is not re-run.

Timing with defaults, input reset:
- rst_sync_n high after edge 2; HOLD entered at edge 3.
- rst_out[0] low after edge 19, rst_out[1] after edge 27, rst_out[2] and seq_done after edge 35.
- General form: release of domain k at edge SYNC_STAGES + 1 + HOLD_CYCLES + k*STEP_CYCLES.

Timing, soft reset accepted at edge S:
- Domain k released at edge S + HOLD_CYCLES + k*STEP_CYCLES.

Soft request rules:
- soft_req outside RUN: ignored, no ack, not queued.
- A requester holding soft_req high after ack does not retrigger; soft_req must be seen low for at least one RUN cycle first.
- soft_armed is 0 out of reset, so soft_req held high from reset is not accepted until it drops.

Other rules:
- reset low mid-HOLD, mid-RELEASE or in RUN: immediate return to ASSERT with reset-state values; the sequence restarts from the synchroniser.
- Once cleared, rst_out bits never reassert except via reset or an accepted soft request. Release order is strictly ascending index.
- Counters are sized $clog2(max(HOLD_CYCLES, STEP_CYCLES)+1). No wrap is reachable.
- All outputs are registered; no combinational path from soft_req or reset to outputs except the asynchronous clear.

Test Plan:
- Reset low 3 cycles then high, defaults -> rst_out = 3'b111 through edge 18; 3'b110 after edge 19; 3'b100 after edge 27; 3'b000 and seq_done = 1 after edge 35.
- In RUN, soft_req high for 1 cycle at edge S=100 -> soft_ack high only in cycle after edge 100, rst_out = 3'b111 and seq_done = 0 from edge 100; release at edges 116, 124, 132.
- soft_req held high 50 cycles from edge 100 -> exactly one soft_ack; no second sequence until soft_req low then high again in RUN.
- Reset pulled low asynchronously mid-edge between edges 22 and 23 -> rst_out = 3'b111 immediately without a clock edge; after release, full sequence repeats with edge count restarted at 1.
- soft_req high during HOLD/RELEASE and during reset -> no soft_ack, sequence timing unchanged; soft_req still high entering RUN is not accepted until it goes low then high.
- NUM_DOMAINS=1, HOLD_CYCLES=1, SYNC_STAGES=2 -> rst_out[0] low and seq_done high after edge 4.
